// File: rtl/bram_seq_writer.sv
// Byte-wide block-RAM store with a sequential stream loader, a constant-pattern fill
// engine and a registered read-first read port.
module bram_seq_writer #(
   parameter int                DATA_W     = 8,
   parameter int                DEPTH      = 9,
   parameter int                ADDR_W     = 4,
   parameter logic [DATA_W-1:0] FILL_VALUE = 8'h01
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_fill,
   input  logic              start_wr,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] wr_count,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] NUM_WORDS = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] wr_count_q, wr_count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              valid_out_q, valid_out_d;

   logic              handshake;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign in_ready  = (state_q == ST_WRITE);
   assign handshake = in_valid & in_ready;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      wr_count_d = wr_count_q;
      done_d     = done_q;
      mem_we     = 1'b0;
      mem_waddr  = wr_ptr_q;
      mem_wdata  = FILL_VALUE;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // A simultaneous fill request takes priority over a streamed load.
            if (start_fill) begin
               state_d  = ST_FILL;
               wr_ptr_d = '0;
               done_d   = 1'b0;
            end else if (start_wr) begin
               state_d    = ST_WRITE;
               wr_ptr_d   = '0;
               wr_count_d = '0;
               done_d     = 1'b0;
            end
         end

         ST_FILL: begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (wr_ptr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end
         end

         ST_WRITE: begin
            if (handshake) begin
               mem_we     = 1'b1;
               mem_wdata  = in_data;
               wr_ptr_d   = wr_ptr_q + ONE;
               wr_count_d = wr_count_q + ONE;
               if (wr_ptr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
            // An abort still lets a same-cycle word land, then drops the load.
            if (abort) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_FILL) || (state_d == ST_WRITE);
   end

   always_comb begin
      valid_out_d = rd_en;
      data_out_d  = data_out_q;
      if (rd_en) begin
         data_out_d = (rd_addr < NUM_WORDS) ? mem[rd_addr] : '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         wr_count_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_count_q  <= wr_count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign wr_count  = wr_count_q;
   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_bram_seq_writer.sv
// Directed-plus-random bench for bram_seq_writer; a plain array and counters model the
// store, and every output is compared against that model.
module tb_bram_seq_writer;

   localparam int          DATA_W = 8;
   localparam int          DEPTH  = 9;
   localparam int          ADDR_W = 4;
   localparam logic [7:0]  FILL   = 8'h01;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_fill, start_wr, abort;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              busy, done;
   logic [ADDR_W-1:0] wr_count;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_mem [DEPTH];
   int         m_ptr;

   bram_seq_writer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL_VALUE(FILL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_fill(start_fill), .start_wr(start_wr),
      .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .done(done), .wr_count(wr_count), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(data_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_expect(input logic [3:0] addr, input string tag);
      logic [7:0] exp;
      exp = (addr < DEPTH) ? m_mem[addr] : 8'h00;
      rd_en   = 1'b1;
      rd_addr = addr;
      tick();
      rd_en = 1'b0;
      check($sformatf("%s valid_out a%0d", tag, addr), valid_out, 1);
      check($sformatf("%s data_out a%0d", tag, addr), data_out, exp);
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < DEPTH; a++) read_expect(4'(a), tag);
   endtask

   // Launches a fill (optionally with a colliding start_wr) and measures the busy window.
   task automatic run_fill(input bit with_wr, input string tag);
      int cnt;
      bit rdy_seen;
      start_fill = 1'b1;
      start_wr   = with_wr;
      tick();
      start_fill = 1'b0;
      start_wr   = 1'b0;
      cnt      = 0;
      rdy_seen = 1'b0;
      while (busy === 1'b1 && cnt < 100) begin
         if (in_ready !== 1'b0) rdy_seen = 1'b1;
         cnt++;
         tick();
      end
      check({tag, " busy cycles"}, cnt, DEPTH);
      check({tag, " in_ready stayed low"}, rdy_seen, 0);
      check({tag, " done after fill"}, done, 0);
      for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
   endtask

   task automatic start_write(input string tag);
      start_wr = 1'b1;
      tick();
      start_wr = 1'b0;
      m_ptr = 0;
      check({tag, " busy"}, busy, 1);
      check({tag, " in_ready"}, in_ready, 1);
      check({tag, " done cleared"}, done, 0);
      check({tag, " wr_count cleared"}, wr_count, 0);
   endtask

   task automatic push_word(input logic [7:0] d, input int idle, input string tag);
      for (int k = 0; k < idle; k++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         tick();
         check({tag, " stall wr_count"}, wr_count, m_ptr);
      end
      in_valid = 1'b1;
      in_data  = d;
      check({tag, " in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      m_mem[m_ptr] = d;
      m_ptr++;
      check({tag, " wr_count"}, wr_count, m_ptr);
   endtask

   task automatic random_load(input string tag);
      start_write(tag);
      for (int i = 0; i < DEPTH; i++) push_word(8'($urandom), int'($urandom_range(0, 2)), tag);
      check({tag, " done"}, done, 1);
      check({tag, " busy"}, busy, 0);
      check({tag, " in_ready"}, in_ready, 0);
   endtask

   initial begin
      logic [7:0] d;
      rst_n = 1'b0; start_fill = 1'b0; start_wr = 1'b0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
      #12;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset in_ready", in_ready, 0);
      check("reset wr_count", wr_count, 0);
      check("reset data_out", data_out, 0);
      check("reset valid_out", valid_out, 0);
      rst_n = 1'b1;
      tick();

      // 1: fill, then sweep every address
      run_fill(1'b0, "fill");
      read_all("fill read");

      // 2: full load of 0x10..0x18 with in_valid held high
      start_write("load");
      for (int i = 0; i < DEPTH; i++) push_word(8'h10 + 8'(i), 0, "load");
      check("load done", done, 1);
      check("load wr_count", wr_count, DEPTH);
      check("load in_ready", in_ready, 0);
      read_expect(4'd4, "load");
      check("load addr4 literal", data_out, 8'h14);
      tick();
      check("done held in DONE", done, 1);

      // 3: toggled valid, abort after three handshakes
      run_fill(1'b0, "refill");
      start_write("abort");
      push_word(8'($urandom), 0, "abort");
      push_word(8'($urandom), 1, "abort");
      push_word(8'($urandom), 1, "abort");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort in_ready", in_ready, 0);
      check("abort wr_count", wr_count, 3);
      for (int a = 0; a < 4; a++) read_expect(4'(a), "abort read");
      check("abort addr3 still fill", data_out, FILL);

      // abort in the same cycle as a handshake still writes that word
      start_write("abort_hs");
      push_word(8'($urandom), 0, "abort_hs");
      d = 8'($urandom);
      in_valid = 1'b1; in_data = d; abort = 1'b1;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      m_mem[1] = d;
      check("abort_hs wr_count", wr_count, 2);
      check("abort_hs busy", busy, 0);
      check("abort_hs done", done, 0);
      read_expect(4'd0, "abort_hs");
      read_expect(4'd1, "abort_hs");

      // random load with random stalls, then random reads including out-of-range
      random_load("rand");
      for (int i = 0; i < 12; i++) read_expect(4'($urandom_range(0, 15)), "rand read");

      // 4: colliding starts -> fill wins, wr_count untouched
      run_fill(1'b1, "collide");
      check("collide wr_count kept", wr_count, DEPTH);
      read_all("collide read");

      // 5: read-first collision during WRITE
      start_write("rf");
      push_word(8'($urandom), 0, "rf");
      push_word(8'($urandom), 0, "rf");
      in_valid = 1'b1; in_data = 8'hAA; rd_en = 1'b1; rd_addr = 4'd2;
      tick();
      in_valid = 1'b0; rd_en = 1'b0;
      check("rf old word", data_out, m_mem[2]);
      check("rf old valid", valid_out, 1);
      m_mem[2] = 8'hAA;
      m_ptr = 3;
      check("rf wr_count", wr_count, 3);
      read_expect(4'd15, "rf oob");
      read_expect(4'd2, "rf new");
      tick();
      check("rd_en low valid_out", valid_out, 0);
      check("rd_en low data holds", data_out, 8'hAA);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("rf abort wr_count", wr_count, 3);

      // 6: reset in the middle of a fill
      random_load("pre_rst");
      start_fill = 1'b1;
      tick();
      start_fill = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("mid fill busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid rst busy", busy, 0);
      check("mid rst done", done, 0);
      check("mid rst in_ready", in_ready, 0);
      check("mid rst wr_count", wr_count, 0);
      check("mid rst valid_out", valid_out, 0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) m_mem[i] = FILL;
      tick();
      check("post rst busy", busy, 0);
      read_all("post rst read");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
